// File: rtl/rtl_hc_adder_if.sv
// Operand/result bundle for rtl_hc_adder.
// The master drives a and b; the slave returns the registered sum y.
interface rtl_hc_adder_if #(
   parameter int N = 64
) ();
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] y;

   modport master (
      output a,
      output b,
      input  y
   );

   modport slave (
      input  a,
      input  b,
      output y
   );
endinterface

// File: rtl/rtl_hc_adder.sv
// Registered Han-Carlson prefix adder, y = (a + b) mod 2^N.
// Define RTL_HC_IN_REG_EN to register a/b ahead of the prefix network (latency 2).
module rtl_hc_adder #(
   parameter int N = 64
) (
   input  logic           clk,
   input  logic           rst,
   rtl_hc_adder_if.slave  bus
);

   localparam int LG = $clog2(N);

   logic [N-1:0] w_a;
   logic [N-1:0] w_b;
   logic [N-1:0] w_g;
   logic [N-1:0] w_p;
   logic [N-1:0] w_gc;
   logic [N-1:0] w_pc;
   logic [N-1:0] w_gn;
   logic [N-1:0] w_pn;
   logic [N-1:0] w_sum;
   logic [N-1:0] r_y;

`ifdef RTL_HC_IN_REG_EN
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= bus.a;
         r_b <= bus.b;
      end
   end

   assign w_a = r_a;
   assign w_b = r_b;
`else
   assign w_a = bus.a;
   assign w_b = bus.b;
`endif

   assign w_g = w_a & w_b;
   assign w_p = w_a ^ w_b;

   // Odd bits carry the full Kogge-Stone tree; even bits are fixed up last.
   always_comb begin
      w_gc = w_g;
      w_pc = w_p;
      w_gn = w_g;
      w_pn = w_p;
      for (int i = 1; i < N; i += 2) begin
         w_gn[i] = w_gc[i] | (w_pc[i] & w_gc[i-1]);
         w_pn[i] = w_pc[i] & w_pc[i-1];
      end
      w_gc = w_gn;
      w_pc = w_pn;
      for (int s = 1; s < LG; s++) begin
         for (int i = 1; i < N; i += 2) begin
            if (i >= (1 << s) + 1) begin
               w_gn[i] = w_gc[i] | (w_pc[i] & w_gc[i-(1<<s)]);
               w_pn[i] = w_pc[i] & w_pc[i-(1<<s)];
            end
         end
         w_gc = w_gn;
         w_pc = w_pn;
      end
      for (int i = 2; i < N; i += 2) begin
         w_gn[i] = w_g[i] | (w_p[i] & w_gc[i-1]);
         w_pn[i] = w_p[i] & w_pc[i-1];
      end
      w_gc = w_gn;
      w_pc = w_pn;
   end

   assign w_sum[0]     = w_p[0];
   assign w_sum[N-1:1] = w_p[N-1:1] ^ w_gc[N-2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y <= '0;
      end else begin
         r_y <= w_sum;
      end
   end

   assign bus.y = r_y;

endmodule

// File: tb/tb_rtl_hc_adder.sv
// Self-checking bench for rtl_hc_adder: directed vectors plus a
// streaming run against a latency-aligned (a+b) mod 2^64 model.
module tb_rtl_hc_adder;

`ifdef RTL_HC_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   rtl_hc_adder_if #(.N(64)) bus ();

   rtl_hc_adder #(.N(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Model history: index 0 is the most recent rising edge.
   logic [63:0] h_a [2] = '{64'd0, 64'd0};
   logic [63:0] h_b [2] = '{64'd0, 64'd0};
   logic        h_r [2] = '{1'b1, 1'b1};
   int          n_edges = 0;

   function automatic logic [63:0] model_y();
      logic any_rst;
      any_rst = 1'b0;
      for (int k = 0; k < LAT; k++) any_rst |= h_r[k];
      return any_rst ? 64'd0 : h_a[LAT-1] + h_b[LAT-1];
   endfunction

   always @(posedge clk) begin
      h_a[1] = h_a[0];
      h_b[1] = h_b[0];
      h_r[1] = h_r[0];
      h_a[0] = bus.a;
      h_b[0] = bus.b;
      h_r[0] = rst;
      n_edges++;
      #1;
      if (n_edges >= LAT) check("model", bus.y, model_y());
   end

   task automatic apply(input string nm, input logic [63:0] va,
                        input logic [63:0] vb, input logic [63:0] ey);
      @(negedge clk);
      bus.a = va;
      bus.b = vb;
      repeat (LAT) @(posedge clk);
      #2;
      check(nm, bus.y, ey);
      @(posedge clk);
      #2;
      check({nm, "_hold"}, bus.y, ey);
   endtask

   initial begin
      bus.a = '1;
      bus.b = '1;
      rst   = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #2;
         check("reset_hold", bus.y, 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release", bus.y, 64'd0);

      apply("random_pair", 64'h17705351ef640b95, 64'h4d4efe8b5d14f84f,
            64'h64bf51dd4c7903e4);
      apply("zero", 64'd0, 64'd0, 64'd0);
      apply("wrap_ones", 64'hffffffffffffffff, 64'hffffffffffffffff,
            64'hfffffffffffffffe);
      apply("wrap_one", 64'hffffffffffffffff, 64'd1, 64'd0);
      apply("ripple", 64'h7fffffffffffffff, 64'd1, 64'h8000000000000000);
      apply("alternating", 64'haaaaaaaaaaaaaaaa, 64'h5555555555555556, 64'd0);

      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (i == 501) check("mid_reset", bus.y, 64'd0);
         bus.a = {$urandom, $urandom};
         bus.b = {$urandom, $urandom};
         rst   = (i == 500);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
